// File: rtl/basic_io_led_arb_pkg.sv
// rtl/basic_io_led_arb_pkg.sv - shared state type, default widths and helpers for the LED arbiter.
// Optional statistics build: BASIC_IO_LED_ARB_STATS_EN.
package basic_io_led_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_OPEN = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_LED_W       = 8;
  localparam int DEF_HOLD_CYCLES = 1000;
  localparam int DEF_OWNER_W     = $clog2(DEF_NUM_REQ);
  localparam int DEF_CNT_W       = $clog2(DEF_HOLD_CYCLES);

  localparam int STATS_W = 16;
  localparam logic [STATS_W-1:0] STATS_MAX = '1;

  function automatic int owner_w(input int num_req);
    return $clog2(num_req);
  endfunction

  function automatic int cnt_w(input int hold_cycles);
    return $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/basic_io_rr_pick.sv
// rtl/basic_io_rr_pick.sv - combinational round-robin pick over a request vector.
// First eligible request at or after start (wrapping) wins; excluded bits never win.
module basic_io_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  input  logic [NUM_REQ-1:0] excl,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  logic [NUM_REQ-1:0] elig;

  assign elig = req & ~excl;

  always_comb begin
    int k;
    k         = 0;
    pick      = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(start) + i) % NUM_REQ;
      if (!any_valid && elig[k]) begin
        any_valid = 1'b1;
        pick[k]   = 1'b1;
        idx       = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/basic_io_led_arbiter.sv
// rtl/basic_io_led_arbiter.sv - round-robin owner of the LED bank with a minimum hold time.
// Define BASIC_IO_LED_ARB_STATS_EN to add the saturating o_handover_cnt output.
module basic_io_led_arbiter
  import basic_io_led_arb_pkg::*;
#(
  parameter int               NUM_REQ      = DEF_NUM_REQ,
  parameter int               LED_W        = DEF_LED_W,
  parameter int               HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter logic [LED_W-1:0] IDLE_PATTERN = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*LED_W-1:0]   i_led_data,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
  output logic                       o_busy,
  output logic [LED_W-1:0]           o_leds
`ifdef BASIC_IO_LED_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]         o_handover_cnt
`endif
);

  localparam int OWNER_W = owner_w(NUM_REQ);
  localparam int CNT_W   = cnt_w(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_REQ - 1);

  arb_state_e         state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [OWNER_W-1:0] owner_n;
  logic               busy_n;
  logic [LED_W-1:0]   leds_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [OWNER_W-1:0] last_owner, last_n;

  logic [OWNER_W-1:0] base, start;
  logic [NUM_REQ-1:0] excl, pick;
  logic [OWNER_W-1:0] pick_idx;
  logic               pick_valid;
  logic               owner_req;
  logic               take;

  // While owned, search from the owner so a handover never re-picks it.
  assign base      = o_busy ? o_owner : last_owner;
  assign start     = (base == LAST_IDX) ? '0 : base + 1'b1;
  assign excl      = o_busy ? o_gnt : '0;
  assign owner_req = |(i_req & o_gnt);

  basic_io_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWNER_W)
  ) u_pick (
    .req       (i_req),
    .start     (start),
    .excl      (excl),
    .pick      (pick),
    .idx       (pick_idx),
    .any_valid (pick_valid)
  );

  always_comb begin
    state_n = state;
    gnt_n   = o_gnt;
    owner_n = o_owner;
    busy_n  = o_busy;
    cnt_n   = cnt;
    last_n  = last_owner;
    take    = 1'b0;

    case (state)
      ARB_IDLE: begin
        take = pick_valid;
      end
      ARB_HOLD: begin
        if (!owner_req) begin
          last_n = o_owner;
          take   = pick_valid;
        end else if (cnt <= CNT_ONE) begin
          state_n = ARB_OPEN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ARB_OPEN: begin
        if (!owner_req || pick_valid) begin
          last_n = o_owner;
          take   = pick_valid;
        end
      end
      default: begin
        state_n = ARB_IDLE;
      end
    endcase

    if (take) begin
      state_n = ARB_HOLD;
      gnt_n   = pick;
      owner_n = pick_idx;
      busy_n  = 1'b1;
      cnt_n   = CNT_LOAD;
    end else if (state != ARB_IDLE && !owner_req) begin
      state_n = ARB_IDLE;
      gnt_n   = '0;
      busy_n  = 1'b0;
      cnt_n   = '0;
    end
  end

  always_comb begin
    leds_n = IDLE_PATTERN;
    if (busy_n) leds_n = i_led_data[int'(owner_n)*LED_W +: LED_W];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= ARB_IDLE;
      o_gnt      <= '0;
      o_owner    <= '0;
      o_busy     <= 1'b0;
      o_leds     <= IDLE_PATTERN;
      cnt        <= '0;
      last_owner <= LAST_IDX;
    end else begin
      state      <= state_n;
      o_gnt      <= gnt_n;
      o_owner    <= owner_n;
      o_busy     <= busy_n;
      o_leds     <= leds_n;
      cnt        <= cnt_n;
      last_owner <= last_n;
    end
  end

`ifdef BASIC_IO_LED_ARB_STATS_EN
  // Every take is a new owner: handovers exclude the incumbent, IDLE grants always count.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_handover_cnt <= '0;
    end else if (take && o_handover_cnt != STATS_MAX) begin
      o_handover_cnt <= o_handover_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_basic_io_led_arbiter.sv
// tb/tb_basic_io_led_arbiter.sv - directed self-checking bench for basic_io_led_arbiter.
// Runs with NUM_REQ=4, LED_W=8, HOLD_CYCLES=4.
module tb_basic_io_led_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [7:0]  dat [0:3];
  logic [31:0] led_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  leds;
`ifdef BASIC_IO_LED_ARB_STATS_EN
  logic [15:0] handover_cnt;
`endif

  int errors = 0;
  int checks = 0;

  assign led_data = {dat[3], dat[2], dat[1], dat[0]};

  basic_io_led_arbiter #(
    .NUM_REQ      (4),
    .LED_W        (8),
    .HOLD_CYCLES  (4),
    .IDLE_PATTERN (8'h00)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_req      (req),
    .i_led_data (led_data),
    .o_gnt      (gnt),
    .o_owner    (owner),
    .o_busy     (busy),
    .o_leds     (leds)
`ifdef BASIC_IO_LED_ARB_STATS_EN
    ,
    .o_handover_cnt (handover_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstn   = 1'b0;
    req    = 4'b0000;
    dat[0] = 8'h11;
    dat[1] = 8'h22;
    dat[2] = 8'hA5;
    dat[3] = 8'h3C;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt",   32'(gnt),   32'h0);
    chk("reset_busy",  32'(busy),  32'h0);
    chk("reset_leds",  32'(leds),  32'h00);
    chk("reset_owner", 32'(owner), 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_gnt",  32'(gnt),  32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_leds", 32'(leds), 32'h00);
    end

    req = 4'b0100;
    step();
    chk("single_gnt",   32'(gnt),   32'h4);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_busy",  32'(busy),  32'h1);
    chk("single_leds",  32'(leds),  32'hA5);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("single_hold_gnt",  32'(gnt),  32'h4);
      chk("single_hold_leds", 32'(leds), 32'hA5);
    end
    req = 4'b0000;
    step();
    chk("release_gnt",  32'(gnt),  32'h0);
    chk("release_busy", 32'(busy), 32'h0);
    chk("release_leds", 32'(leds), 32'h00);

    rstn = 1'b0;
    step();
    rstn = 1'b1;
    req  = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      int k;
      k = (i / 4) % 4;
      step();
      chk("rr_gnt",   32'(gnt),   32'(4'b0001 << k));
      chk("rr_owner", 32'(owner), 32'(k));
      chk("rr_leds",  32'(leds),  32'(dat[k]));
    end

    step();
    chk("early_gnt_a", 32'(gnt), 32'h2);
    step();
    chk("early_gnt_b", 32'(gnt), 32'h2);
    req = 4'b1000;
    step();
    chk("early_rel_gnt",   32'(gnt),   32'h8);
    chk("early_rel_owner", 32'(owner), 32'h3);
    chk("early_rel_busy",  32'(busy),  32'h1);
    chk("early_rel_leds",  32'(leds),  32'h3C);

    req = 4'b0001;
    step();
    chk("own0_gnt",  32'(gnt),  32'h1);
    chk("own0_leds", 32'(leds), 32'h11);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("own0_hold_gnt", 32'(gnt), 32'h1);
    end
    req = 4'b0101;
    step();
    chk("open_ho_gnt",   32'(gnt),   32'h4);
    chk("open_ho_owner", 32'(owner), 32'h2);
    chk("open_ho_leds",  32'(leds),  32'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_preempt_gnt", 32'(gnt), 32'h4);
    end
    step();
    chk("back_to0_gnt",   32'(gnt),   32'h1);
    chk("back_to0_owner", 32'(owner), 32'h0);
    dat[0] = 8'h5A;
    step();
    chk("data_follow_leds", 32'(leds), 32'h5A);

    rstn = 1'b0;
    #1;
    chk("async_rst_gnt",  32'(gnt),  32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_leds", 32'(leds), 32'h00);
    req = 4'b0011;
    @(negedge clk);
    chk("in_rst_gnt", 32'(gnt), 32'h0);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_gnt",  32'(gnt),  (i < 4) ? 32'h1 : 32'h2);
      chk("post_rst_leds", 32'(leds), (i < 4) ? 32'h5A : 32'h22);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
